// File: rtl/ms_arbiter.sv
// ms_arbiter -- three-requester main store arbiter.
//
// Arbitrates between the machine (M), typewriter manual entry (T) and the
// display refresh scanner (D) for one main store access at a time. Each
// granted access lasts ACCESS_CYCLES cycles, followed by one RELEASE cycle
// and one IDLE cycle before the next arbitration. Fixed priority M > T > D.
//
// Optional feature (compile-time macro MS_ARB_STARVE_GUARD_EN):
//   when defined, a starve counter forces a D grant once STARVE_LIMIT
//   consecutive M/T grants have been issued while D was waiting. When
//   undefined, priority is strictly M > T > D and no starve logic exists.
//
// Ports:
//   w_CLK                          system clock, rising edge
//   w_RST                          synchronous active-high reset
//   w_REQ_M / w_REQ_T / w_REQ_D    requests
//   b_ADDR_M / b_ADDR_T / b_ADDR_D requested line addresses
//   w_WR_M / w_WR_T                write flags (D always reads)
//   b_GNT                          one-hot grant {D, T, M}
//   b_MS_ADDR                      main store address
//   w_MS_EN                        main store access enable
//   w_MS_WR                        main store write qualifier
//   w_DONE                         pulse on the last cycle of a completed access

module ms_arbiter #(
  parameter int ADDR_BITS     = 10,
  parameter int ACCESS_CYCLES = 9,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                 w_CLK,
  input  logic                 w_RST,
  input  logic                 w_REQ_M,
  input  logic                 w_REQ_T,
  input  logic                 w_REQ_D,
  input  logic [ADDR_BITS-1:0] b_ADDR_M,
  input  logic [ADDR_BITS-1:0] b_ADDR_T,
  input  logic [ADDR_BITS-1:0] b_ADDR_D,
  input  logic                 w_WR_M,
  input  logic                 w_WR_T,
  output logic [2:0]           b_GNT,
  output logic [ADDR_BITS-1:0] b_MS_ADDR,
  output logic                 w_MS_EN,
  output logic                 w_MS_WR,
  output logic                 w_DONE
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [2:0] GNT_M    = 3'b001;
  localparam logic [2:0] GNT_T    = 3'b010;
  localparam logic [2:0] GNT_D    = 3'b100;
  localparam logic [7:0] CNT_LOAD = 8'(ACCESS_CYCLES - 1);

  generate
    if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 255) begin : g_bad_access_cycles
      $error("ms_arbiter: ACCESS_CYCLES must be in 2..255");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
      $error("ms_arbiter: STARVE_LIMIT must be in 1..255");
    end
  endgenerate

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [2:0]           gnt_q, gnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 wr_q, wr_d;

  logic                 any_req;
  logic                 starve_hit;
  logic                 owner_req;
  logic [2:0]           win_gnt;
  logic [ADDR_BITS-1:0] win_addr;
  logic                 win_wr;

  assign any_req = w_REQ_M | w_REQ_T | w_REQ_D;

`ifdef MS_ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [7:0] starve_q, starve_d;

  // The counter never passes STARVE_MAX: reaching it forces the next grant to D.
  assign starve_hit = w_REQ_D && (starve_q >= STARVE_MAX);

  always_comb begin
    starve_d = starve_q;
    if (!w_REQ_D) begin
      starve_d = '0;
    end else if (state_q == ST_IDLE) begin
      // D is requesting, so a grant is being issued this cycle.
      if (win_gnt == GNT_D) starve_d = '0;
      else if (starve_q != 8'hFF) starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge w_CLK) begin
    if (w_RST) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Winner selection for the arbitration made in IDLE.
  always_comb begin
    win_gnt  = '0;
    win_addr = '0;
    win_wr   = 1'b0;
    if (starve_hit) begin
      win_gnt  = GNT_D;
      win_addr = b_ADDR_D;
    end else if (w_REQ_M) begin
      win_gnt  = GNT_M;
      win_addr = b_ADDR_M;
      win_wr   = w_WR_M;
    end else if (w_REQ_T) begin
      win_gnt  = GNT_T;
      win_addr = b_ADDR_T;
      win_wr   = w_WR_T;
    end else if (w_REQ_D) begin
      win_gnt  = GNT_D;
      win_addr = b_ADDR_D;
    end
  end

  // Live request of whoever currently owns the store; a drop aborts the access.
  always_comb begin
    case (gnt_q)
      GNT_M:   owner_req = w_REQ_M;
      GNT_T:   owner_req = w_REQ_T;
      GNT_D:   owner_req = w_REQ_D;
      default: owner_req = 1'b0;
    endcase
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    b_GNT     = '0;
    b_MS_ADDR = '0;
    w_MS_EN   = 1'b0;
    w_MS_WR   = 1'b0;
    w_DONE    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          cnt_d   = CNT_LOAD;
          gnt_d   = win_gnt;
          addr_d  = win_addr;
          wr_d    = win_wr;
        end
      end
      ST_GRANT: begin
        b_GNT     = gnt_q;
        b_MS_ADDR = addr_q;
        w_MS_EN   = 1'b1;
        w_MS_WR   = wr_q & owner_req;
        if (!owner_req) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == 8'd0) begin
          // A reset landing on the final cycle aborts, so no completion pulse.
          w_DONE  = ~w_RST;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge w_CLK) begin
    if (w_RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_ms_arbiter.sv
// tb_ms_arbiter -- self-checking bench for ms_arbiter (default parameters).
// A per-cycle table of {inputs, expected outputs} is built first, then driven
// one row per cycle; each driven row is queued and a negedge monitor pops and
// compares it. A hand-written sequence then checks first arbitration after
// reset and completion latency with a bounded wait.

module tb_ms_arbiter;

  localparam int AB = 10;
  localparam int AC = 9;

`ifdef MS_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    string         nm;
    logic          rst;
    logic [2:0]    req;   // {D, T, M}
    logic [1:0]    wr;    // {T, M}
    logic [AB-1:0] am;
    logic [AB-1:0] at;
    logic [AB-1:0] ad;
    logic [2:0]    gnt;
    logic [AB-1:0] addr;
    logic          en;
    logic          wr_o;
    logic          done;
  } vec_t;

  logic          clk;
  logic          rst, rm, rt, rd, wm, wt;
  logic [AB-1:0] am, at, ad;
  logic [2:0]    b_gnt;
  logic [AB-1:0] b_ms_addr;
  logic          ms_en, ms_wr, done;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];
  vec_t sb[$];
  logic [AB-1:0] tam, tat, tad;

  ms_arbiter dut (
    .w_CLK     (clk),
    .w_RST     (rst),
    .w_REQ_M   (rm),
    .w_REQ_T   (rt),
    .w_REQ_D   (rd),
    .b_ADDR_M  (am),
    .b_ADDR_T  (at),
    .b_ADDR_D  (ad),
    .w_WR_M    (wm),
    .w_WR_T    (wt),
    .b_GNT     (b_gnt),
    .b_MS_ADDR (b_ms_addr),
    .w_MS_EN   (ms_en),
    .w_MS_WR   (ms_wr),
    .w_DONE    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic rst_v, input logic [2:0] req,
                      input logic [1:0] wr, input logic [2:0] gnt, input logic [AB-1:0] addr,
                      input logic en, input logic wr_o, input logic dn);
    vec_t v;
    v.nm = nm; v.rst = rst_v; v.req = req; v.wr = wr;
    v.am = tam; v.at = tat; v.ad = tad;
    v.gnt = gnt; v.addr = addr; v.en = en; v.wr_o = wr_o; v.done = dn;
    vecs.push_back(v);
  endtask

  task automatic push_zero(input string nm, input logic rst_v, input logic [2:0] req,
                           input logic [1:0] wr);
    push(nm, rst_v, req, wr, 3'b000, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // A full completed access: AC grant cycles, w_DONE on the last one.
  task automatic push_grant(input string nm, input logic [2:0] req, input logic [1:0] wr,
                            input logic [2:0] gnt, input logic [AB-1:0] addr, input logic wr_o);
    for (int i = 1; i <= AC; i++)
      push($sformatf("%s_c%0d", nm, i), 1'b0, req, wr, gnt, addr, 1'b1, wr_o, i == AC);
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; rm = v.req[0]; rt = v.req[1]; rd = v.req[2];
    wm = v.wr[0]; wt = v.wr[1];
    am = v.am; at = v.at; ad = v.ad;
  endtask

  // Scoreboard monitor: compare each driven row on the falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      vec_t e;
      e = sb.pop_front();
      check(e.nm, 32'({b_gnt, b_ms_addr, ms_en, ms_wr, done}),
            32'({e.gnt, e.addr, e.en, e.wr_o, e.done}));
    end
  end

  initial begin
    int n;
    rst = 1'b1; rm = 0; rt = 0; rd = 0; wm = 0; wt = 0;
    am = '0; at = '0; ad = '0;
    tam = 10'h011; tat = 10'd5; tad = 10'h3A0;

    // ---- reset behaviour
    push_zero("rst_idle", 1'b1, 3'b000, 2'b00);
    push_zero("rst_blocks_arb", 1'b1, 3'b001, 2'b01);
    push_zero("post_rst_idle", 1'b0, 3'b000, 2'b00);

    // ---- single T read of line 5; T's inputs wiggle during the grant
    push_zero("t_rd_arb", 1'b0, 3'b010, 2'b00);
    tat = 10'h2AA;
    push_grant("t_rd", 3'b010, 2'b10, 3'b010, 10'd5, 1'b0);
    tat = 10'd5;
    push_zero("t_rd_release", 1'b0, 3'b000, 2'b00);
    push_zero("t_rd_idle", 1'b0, 3'b000, 2'b00);

    // ---- M write and D together: M first, D 11 cycles later, D never writes
    push_zero("md_arb", 1'b0, 3'b101, 2'b01);
    push_grant("md_m", 3'b101, 2'b01, 3'b001, 10'h011, 1'b1);
    push_zero("md_release", 1'b0, 3'b100, 2'b01);
    push_zero("md_idle", 1'b0, 3'b100, 2'b01);
    push_grant("md_d", 3'b100, 2'b11, 3'b100, 10'h3A0, 1'b0);
    push_zero("md_d_release", 1'b0, 3'b000, 2'b00);
    push_zero("md_d_idle", 1'b0, 3'b000, 2'b00);

    // ---- abort: M write drops its request in grant cycle 3
    push_zero("ab_arb", 1'b0, 3'b001, 2'b01);
    push("ab_c1", 1'b0, 3'b001, 2'b01, 3'b001, 10'h011, 1'b1, 1'b1, 1'b0);
    push("ab_c2", 1'b0, 3'b001, 2'b01, 3'b001, 10'h011, 1'b1, 1'b1, 1'b0);
    push("ab_c3_drop", 1'b0, 3'b000, 2'b01, 3'b001, 10'h011, 1'b1, 1'b0, 1'b0);
    push_zero("ab_release", 1'b0, 3'b000, 2'b01);
    push_zero("ab_idle", 1'b0, 3'b000, 2'b00);

    // ---- reset in grant cycle 5 of a T write, then re-arbitration
    push_zero("rm_arb", 1'b0, 3'b010, 2'b10);
    for (int i = 1; i <= 4; i++)
      push($sformatf("rm_c%0d", i), 1'b0, 3'b010, 2'b10, 3'b010, 10'd5, 1'b1, 1'b1, 1'b0);
    push("rm_c5_rst", 1'b1, 3'b010, 2'b10, 3'b010, 10'd5, 1'b1, 1'b1, 1'b0);
    push_zero("rm_after_rst", 1'b0, 3'b010, 2'b10);
    push_grant("rm_rearb", 3'b010, 2'b10, 3'b010, 10'd5, 1'b1);
    push_zero("rm_release", 1'b0, 3'b000, 2'b00);
    push_zero("rm_idle", 1'b0, 3'b000, 2'b00);

    // ---- reset on the final grant cycle suppresses w_DONE
    push_zero("rd_arb", 1'b0, 3'b010, 2'b00);
    for (int i = 1; i < AC; i++)
      push($sformatf("rd_c%0d", i), 1'b0, 3'b010, 2'b00, 3'b010, 10'd5, 1'b1, 1'b0, 1'b0);
    push("rd_last_rst", 1'b1, 3'b010, 2'b00, 3'b010, 10'd5, 1'b1, 1'b0, 1'b0);
    push_zero("rd_after_rst", 1'b0, 3'b000, 2'b00);

    // ---- all three at once: M, then T, then D
    push_zero("p3_arb", 1'b0, 3'b111, 2'b00);
    push_grant("p3_m", 3'b111, 2'b00, 3'b001, 10'h011, 1'b0);
    push_zero("p3_m_rel", 1'b0, 3'b110, 2'b00);
    push_zero("p3_idle1", 1'b0, 3'b110, 2'b00);
    push_grant("p3_t", 3'b110, 2'b00, 3'b010, 10'd5, 1'b0);
    push_zero("p3_t_rel", 1'b0, 3'b100, 2'b00);
    push_zero("p3_idle2", 1'b0, 3'b100, 2'b00);
    push_grant("p3_d", 3'b100, 2'b00, 3'b100, 10'h3A0, 1'b0);
    push_zero("p3_d_rel", 1'b0, 3'b000, 2'b00);
    push_zero("p3_idle3", 1'b0, 3'b000, 2'b00);

    // ---- M and D held through five arbitrations
    for (int k = 1; k <= 5; k++) begin
      push_zero($sformatf("sv_arb%0d", k), 1'b0, 3'b101, 2'b00);
      if (GUARD && k == 5)
        push_grant($sformatf("sv_d%0d", k), 3'b101, 2'b00, 3'b100, 10'h3A0, 1'b0);
      else
        push_grant($sformatf("sv_m%0d", k), 3'b101, 2'b00, 3'b001, 10'h011, 1'b0);
      push_zero($sformatf("sv_rel%0d", k), 1'b0, 3'b101, 2'b00);
    end
    push_zero("sv_end", 1'b0, 3'b000, 2'b00);
    push_zero("sv_idle", 1'b0, 3'b000, 2'b00);

    // ---- run the table
    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      apply(vecs[i]);
      sb.push_back(vecs[i]);
    end
    for (int w = 0; w < 4 && sb.size() != 0; w++) begin
      @(negedge clk);
      #1;
    end
    check("sb_drain", 32'(sb.size()), 32'd0);

    // ---- hand-written: first arbitration right after reset, completion latency
    @(posedge clk); #1;
    rst = 1'b1; rm = 1'b1; wm = 1'b1; am = 10'h155;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("hs_idle_after_rst", 32'({b_gnt, ms_en}), 32'd0);
    @(posedge clk); #1;
    am = 10'h0F0;
    @(negedge clk);
    check("hs_first_arb_gnt", 32'(b_gnt), 32'b001);
    check("hs_first_arb_addr", 32'(b_ms_addr), 32'h155);
    check("hs_first_arb_wr", 32'(ms_wr), 32'd1);
    n = 1;
    while (!done && n < 4 * AC) begin
      @(negedge clk);
      n++;
    end
    check("hs_done_latency", 32'(n), 32'(AC));
    @(posedge clk); #1;
    rm = 1'b0; wm = 1'b0;
    @(negedge clk);
    check("hs_release", 32'({b_gnt, ms_en, ms_wr, done}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("hs_idle_end", 32'({b_gnt, ms_en, done}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ms_arbiter.md
MS_ARBITER -- requirements
Module: ms_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 10: main store line address width.
REQ-002 Parameter ACCESS_CYCLES, default 9: cycles per granted access, one beat of sub-cycles; legal range 2..255.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive M/T grants tolerated while D waits; legal range 1..255.
REQ-004 w_CLK  input  1  system clock; all state updates on its rising edge.
REQ-005 w_RST  input  1  reset; synchronous and active-high.
REQ-006 w_REQ_M  input  1  machine (fetch/execute) request.
REQ-007 w_REQ_T  input  1  typewriter manual-entry request.
REQ-008 w_REQ_D  input  1  display refresh scanner request.
REQ-009 b_ADDR_M, b_ADDR_T, b_ADDR_D  input  ADDR_BITS each  requested line address, bit 0 first.
REQ-010 w_WR_M, w_WR_T  input  1 each  write (1) or read (0) for the M and T requests; D is always a read.
REQ-011 b_GNT  output  3  one-hot grant: bit 0 = M, bit 1 = T, bit 2 = D.
REQ-012 b_MS_ADDR  output  ADDR_BITS  address driven to the main store.
REQ-013 w_MS_EN  output  1  main store access enable.
REQ-014 w_MS_WR  output  1  main store write strobe qualifier.
REQ-015 w_DONE  output  1  one-cycle pulse on the final cycle of a completed access.

Function
REQ-016 FSM states: IDLE, GRANT, RELEASE.
REQ-017 IDLE with any request asserted: the arbiter selects a winner, latches its address and write flag, and enters GRANT on the next edge, loading the counter with ACCESS_CYCLES-1.
REQ-018 IDLE with no request asserted: the FSM stays in IDLE and all outputs are 0.
REQ-019 Priority order is M > T > D, except where REQ-026 applies.
REQ-020 GRANT: b_GNT holds the winner's bit, w_MS_EN=1, b_MS_ADDR and w_MS_WR hold the latched values, and the counter decrements each cycle.
REQ-021 The latched address and write flag stay unchanged during GRANT even if the requester's inputs change.
REQ-022 GRANT with counter=0 and the winner's request still asserted: w_DONE=1 that cycle, and the FSM enters RELEASE on the next edge.
REQ-023 Abort: if the winner deasserts its request during GRANT, the FSM enters RELEASE on the next edge, w_DONE is not pulsed, and w_MS_WR is forced to 0 in the cycle the request is seen low.
REQ-024 RELEASE lasts exactly one cycle with all outputs 0, then the FSM returns to IDLE; a new arbitration occurs in IDLE.
REQ-025 Minimum request-to-request spacing is ACCESS_CYCLES+2 cycles, and b_GNT is never more than one-hot.
REQ-026 With the starvation guard compiled in (see Configuration): the starve counter increments on each M or T grant issued while w_REQ_D=1. It clears on a D grant or on any cycle with w_REQ_D=0. When the counter equals STARVE_LIMIT, the next arbitration grants D regardless of M and T.
REQ-027 Simultaneous requests in IDLE are resolved in a single cycle, and losing requests remain pending without any requester-side action.
REQ-028 For a D grant, w_MS_WR=0 always.

Reset
REQ-029 While w_RST=1 at a clock edge, the FSM enters IDLE; the counter and starve counter clear; b_GNT=0, b_MS_ADDR=0, w_MS_EN=0, w_MS_WR=0, w_DONE=0.
REQ-030 Reset asserted during GRANT aborts the access without a w_DONE pulse.
REQ-031 The first arbitration can occur on the first edge after w_RST falls.

Configuration
REQ-032 Macro MS_ARB_STARVE_GUARD_EN defined: REQ-026 is active.
REQ-033 Macro MS_ARB_STARVE_GUARD_EN undefined: strict fixed priority M > T > D, and no starve counter logic is synthesised.

Verification
REQ-034 Single read: w_REQ_T=1, w_WR_T=0, b_ADDR_T=5 -> b_GNT=3'b010 for 9 cycles, b_MS_ADDR=5, w_MS_WR=0, w_DONE on cycle 9, then 1 RELEASE cycle.
REQ-035 Conflict: M and D requesting together in IDLE -> M is granted first; D is granted after M's RELEASE and the following IDLE cycle (11 cycles after M's grant).
REQ-036 Abort: M granted with w_WR_M=1; w_REQ_M dropped in grant cycle 3 -> w_MS_WR=0 that cycle, RELEASE next, no w_DONE.
REQ-037 Starvation (guard on): M is held continuously and D is held; M is granted 4 times, then D is granted on the 5th arbitration. Guard off: D is never granted while M is held.
REQ-038 Reset mid-access: w_RST pulsed in grant cycle 5 -> all outputs 0 on the next cycle, and after release of reset a pending request is re-arbitrated from IDLE.
